control_gw_port_demux: RTL and testbench

Parametrised successor to the single-destination control gateway. It accepts UDP-style AXI-Stream packets from the network bridge and decodes the destination port carried on `tdest` of the first beat. Matching packets are steered to one of `NUM_CHANNELS` control consumers; unmatched packets are dropped and counted. Sideband fields are latched from the first beat and held constant for the whole packet, and the output stage is registered with full backpressure.

---
 rtl/control_gw_port_demux_if.sv | 65 ++++++
 rtl/control_gw_port_demux.sv | 155 +++++++++++++++
 tb/tb_control_gw_port_demux.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_gw_port_demux_if.sv
// rtl/control_gw_port_demux_if.sv - stream bundle: network bridge ingress and shared control-consumer egress
interface control_gw_port_demux_if #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int IP_PORT_WIDTH    = 16,
    parameter int IP_ADDRESS_WIDTH = 32,
    parameter int NUM_CHANNELS     = 2
);
    logic                        from_network_bridge_tvalid;
    logic                        from_network_bridge_tready;
    logic [AXIS_DATA_WIDTH-1:0]  from_network_bridge_tdata;
    logic [AXIS_KEEP_WIDTH-1:0]  from_network_bridge_tkeep;
    logic [IP_PORT_WIDTH-1:0]    from_network_bridge_tid;
    logic [IP_PORT_WIDTH-1:0]    from_network_bridge_tdest;
    logic [IP_ADDRESS_WIDTH-1:0] from_network_bridge_tuser;
    logic                        from_network_bridge_tlast;

    logic [NUM_CHANNELS-1:0]     to_ctrl_tvalid;
    logic [NUM_CHANNELS-1:0]     to_ctrl_tready;
    logic [AXIS_DATA_WIDTH-1:0]  to_ctrl_tdata;
    logic [AXIS_KEEP_WIDTH-1:0]  to_ctrl_tkeep;
    logic [IP_PORT_WIDTH-1:0]    to_ctrl_tid;
    logic [IP_PORT_WIDTH-1:0]    to_ctrl_tdest;
    logic [IP_ADDRESS_WIDTH-1:0] to_ctrl_tuser;
    logic                        to_ctrl_tlast;

    // The demux itself sits on the slave side.
    modport slave (
        input  from_network_bridge_tvalid,
        output from_network_bridge_tready,
        input  from_network_bridge_tdata,
        input  from_network_bridge_tkeep,
        input  from_network_bridge_tid,
        input  from_network_bridge_tdest,
        input  from_network_bridge_tuser,
        input  from_network_bridge_tlast,
        output to_ctrl_tvalid,
        input  to_ctrl_tready,
        output to_ctrl_tdata,
        output to_ctrl_tkeep,
        output to_ctrl_tid,
        output to_ctrl_tdest,
        output to_ctrl_tuser,
        output to_ctrl_tlast
    );

    modport master (
        output from_network_bridge_tvalid,
        input  from_network_bridge_tready,
        output from_network_bridge_tdata,
        output from_network_bridge_tkeep,
        output from_network_bridge_tid,
        output from_network_bridge_tdest,
        output from_network_bridge_tuser,
        output from_network_bridge_tlast,
        input  to_ctrl_tvalid,
        output to_ctrl_tready,
        input  to_ctrl_tdata,
        input  to_ctrl_tkeep,
        input  to_ctrl_tid,
        input  to_ctrl_tdest,
        input  to_ctrl_tuser,
        input  to_ctrl_tlast
    );
endinterface

// File: rtl/control_gw_port_demux.sv
// rtl/control_gw_port_demux.sv - steers packets to one of NUM_CHANNELS consumers by tdest, drops and counts the rest
module control_gw_port_demux #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int IP_PORT_WIDTH    = 16,
    parameter int IP_ADDRESS_WIDTH = 32,
    parameter int NUM_CHANNELS     = 2,
    parameter logic [NUM_CHANNELS*IP_PORT_WIDTH-1:0] PORT_NUMBERS = {16'hEFEF, 16'hABCD},
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_ap_rst_n,
    control_gw_port_demux_if.slave    bus,
    output logic [DROP_CNT_WIDTH-1:0] o_drop_count,
    output logic                      o_busy
);
    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    state_t state, state_nxt;

    logic [SEL_W-1:0]            sel;
    logic                        out_valid;
    logic [AXIS_DATA_WIDTH-1:0]  out_data;
    logic [AXIS_KEEP_WIDTH-1:0]  out_keep;
    logic                        out_last;
    logic [IP_PORT_WIDTH-1:0]    sb_tid;
    logic [IP_PORT_WIDTH-1:0]    sb_tdest;
    logic [IP_ADDRESS_WIDTH-1:0] sb_tuser;
    logic [DROP_CNT_WIDTH-1:0]   drop_count;

    logic                        hit;
    logic [SEL_W-1:0]            hit_idx;
    logic                        in_ready;
    logic                        header_take;
    logic                        accept;
    logic                        load;
    logic                        drop_done;
    logic                        sel_ready;
    logic [NUM_CHANNELS-1:0]     ctrl_tvalid;

    // Scan downward so the lowest matching channel is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (bus.from_network_bridge_tdest == PORT_NUMBERS[c*IP_PORT_WIDTH +: IP_PORT_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(c);
            end
        end
    end

    assign sel_ready = bus.to_ctrl_tready[sel];

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Decode waits for an empty output register so sel never changes under a pending beat.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        header_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.from_network_bridge_tvalid && !out_valid) begin
                    header_take = 1'b1;
                    state_nxt   = hit ? ST_FWD : ST_DROP;
                end
            end
            ST_FWD: begin
                in_ready = !out_valid || sel_ready;
                if (bus.from_network_bridge_tvalid && in_ready && bus.from_network_bridge_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                in_ready = 1'b1;
                if (bus.from_network_bridge_tvalid && bus.from_network_bridge_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept    = bus.from_network_bridge_tvalid && in_ready;
    assign load      = accept && (state == ST_FWD);
    assign drop_done = accept && (state == ST_DROP) && bus.from_network_bridge_tlast;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            sel        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            sb_tid     <= '0;
            sb_tdest   <= '0;
            sb_tuser   <= '0;
            drop_count <= '0;
        end else begin
            if (header_take) begin
                sb_tid   <= bus.from_network_bridge_tid;
                sb_tdest <= bus.from_network_bridge_tdest;
                sb_tuser <= bus.from_network_bridge_tuser;
                if (hit) begin
                    sel <= hit_idx;
                end
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= bus.from_network_bridge_tdata;
                out_keep  <= bus.from_network_bridge_tkeep;
                out_last  <= bus.from_network_bridge_tlast;
            end else if (out_valid && sel_ready) begin
                out_valid <= 1'b0;
            end

            if (drop_done && (drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        ctrl_tvalid = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ctrl_tvalid[c] = out_valid && (sel == SEL_W'(c));
        end
    end

    assign bus.from_network_bridge_tready = in_ready;
    assign bus.to_ctrl_tvalid             = ctrl_tvalid;
    assign bus.to_ctrl_tdata              = out_data;
    assign bus.to_ctrl_tkeep              = out_keep;
    assign bus.to_ctrl_tlast              = out_last;
    assign bus.to_ctrl_tid                = sb_tid;
    assign bus.to_ctrl_tdest              = sb_tdest;
    assign bus.to_ctrl_tuser              = sb_tuser;

    assign o_drop_count = drop_count;
    assign o_busy       = (state != ST_IDLE) || out_valid;
endmodule

// File: tb/tb_control_gw_port_demux.sv
// tb/tb_control_gw_port_demux.sv - directed bench with a packet-level scoreboard for control_gw_port_demux
module tb_control_gw_port_demux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_gw_port_demux_if cif ();
    control_gw_port_demux_if sif ();

    logic [15:0] drop_count;
    logic [1:0]  drop_count_small;
    logic        busy;
    logic        busy_small;

    control_gw_port_demux dut (
        .i_clk        (clk),
        .i_ap_rst_n   (rst_n),
        .bus          (cif),
        .o_drop_count (drop_count),
        .o_busy       (busy)
    );

    control_gw_port_demux #(.DROP_CNT_WIDTH(2)) dut_small (
        .i_clk        (clk),
        .i_ap_rst_n   (rst_n),
        .bus          (sif),
        .o_drop_count (drop_count_small),
        .o_busy       (busy_small)
    );

    assign sif.from_network_bridge_tvalid = cif.from_network_bridge_tvalid;
    assign sif.from_network_bridge_tdata  = cif.from_network_bridge_tdata;
    assign sif.from_network_bridge_tkeep  = cif.from_network_bridge_tkeep;
    assign sif.from_network_bridge_tid    = cif.from_network_bridge_tid;
    assign sif.from_network_bridge_tdest  = cif.from_network_bridge_tdest;
    assign sif.from_network_bridge_tuser  = cif.from_network_bridge_tuser;
    assign sif.from_network_bridge_tlast  = cif.from_network_bridge_tlast;
    assign sif.to_ctrl_tready             = cif.to_ctrl_tready;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] tid;
        logic [15:0] tdest;
        logic [31:0] tuser;
    } beat_t;

    typedef struct {
        int          cyc;
        int          ch;
        logic [63:0] data;
        logic        last;
        logic [15:0] tid;
    } log_t;

    beat_t       exp_q[$];
    bit          pkt_q[$];
    log_t        log_q[$];
    logic [63:0] pd[8];
    int          model_drops;
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          rdy_mode;
    logic [1:0]  rdy_val;

    logic [15:0] port_tab[2] = '{16'hABCD, 16'hEFEF};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int port_lookup(input logic [15:0] d);
        for (int c = 0; c < 2; c++) begin
            if (d == port_tab[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] keep_of(input int i);
        return 8'hFF >> i;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Output ready driver: constant rdy_val, or channel 0 toggling every cycle.
    initial begin
        logic tog;
        tog = 1'b0;
        cif.to_ctrl_tready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            cif.to_ctrl_tready = {rdy_val[1], (rdy_mode == 1) ? tog : rdy_val[0]};
        end
    end

    // Scoreboard / monitor
    logic        hold;
    logic [1:0]  prev_valid;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [15:0] prev_tid;
    initial hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            check("drop_count", drop_count, 64'(sat(model_drops, 65535)));
            check("drop_count_small", drop_count_small, 64'(sat(model_drops, 3)));
            check("tvalid_onehot0", $onehot0(cif.to_ctrl_tvalid), 1);
            if (cif.to_ctrl_tvalid != 2'b00) begin
                check("tvalid_expected", exp_q.size() > 0, 1);
            end
            if (hold) begin
                check("stable_tvalid", cif.to_ctrl_tvalid, prev_valid);
                check("stable_tdata", cif.to_ctrl_tdata, prev_data);
                check("stable_tlast", cif.to_ctrl_tlast, prev_last);
                check("stable_tid", cif.to_ctrl_tid, prev_tid);
            end
            for (int c = 0; c < 2; c++) begin
                if (cif.to_ctrl_tvalid[c] && cif.to_ctrl_tready[c] && exp_q.size() > 0) begin
                    beat_t e;
                    log_t  l;
                    e = exp_q.pop_front();
                    check("out_channel", 64'(c), 64'(e.ch));
                    check("out_tdata", cif.to_ctrl_tdata, e.data);
                    check("out_tkeep", cif.to_ctrl_tkeep, e.keep);
                    check("out_tlast", cif.to_ctrl_tlast, e.last);
                    check("out_tid", cif.to_ctrl_tid, e.tid);
                    check("out_tdest", cif.to_ctrl_tdest, e.tdest);
                    check("out_tuser", cif.to_ctrl_tuser, e.tuser);
                    l.cyc  = cyc;
                    l.ch   = c;
                    l.data = cif.to_ctrl_tdata;
                    l.last = cif.to_ctrl_tlast;
                    l.tid  = cif.to_ctrl_tid;
                    log_q.push_back(l);
                end
            end
            hold       = (cif.to_ctrl_tvalid != 2'b00) && ((cif.to_ctrl_tvalid & cif.to_ctrl_tready) == 2'b00);
            prev_valid = cif.to_ctrl_tvalid;
            prev_data  = cif.to_ctrl_tdata;
            prev_last  = cif.to_ctrl_tlast;
            prev_tid   = cif.to_ctrl_tid;
            if (cif.from_network_bridge_tvalid && cif.from_network_bridge_tready &&
                cif.from_network_bridge_tlast && pkt_q.size() > 0) begin
                if (pkt_q.pop_front()) model_drops++;
            end
        end
    end

    // Sends n_send of n beats from pd[]; tid switches to id_rest after the header.
    task automatic send_pkt(input logic [15:0] dest, input logic [15:0] id, input logic [15:0] id_rest,
                            input logic [31:0] user, input int n, input int n_send,
                            output int t_first, output int t_last);
        int    ch;
        int    waited;
        beat_t e;
        ch = port_lookup(dest);
        pkt_q.push_back(ch < 0);
        if (ch >= 0) begin
            for (int i = 0; i < n; i++) begin
                e.ch = ch; e.data = pd[i]; e.keep = keep_of(i); e.last = (i == n - 1);
                e.tid = id; e.tdest = dest; e.tuser = user;
                exp_q.push_back(e);
            end
        end
        t_first = cyc;
        t_last  = cyc;
        for (int i = 0; i < n_send; i++) begin
            cif.from_network_bridge_tdata  = pd[i];
            cif.from_network_bridge_tkeep  = keep_of(i);
            cif.from_network_bridge_tid    = (i == 0) ? id : id_rest;
            cif.from_network_bridge_tdest  = dest;
            cif.from_network_bridge_tuser  = user;
            cif.from_network_bridge_tlast  = (i == n - 1);
            cif.from_network_bridge_tvalid = 1'b1;
            waited = 0;
            @(negedge clk);
            while (!cif.from_network_bridge_tready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            check("in_accept_timeout", waited < 100, 1);
            t_last = cyc;
            @(posedge clk);
            #1;
        end
        cif.from_network_bridge_tvalid = 1'b0;
        cif.from_network_bridge_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int t0, tl, base;
        int exp6[5] = '{1, 2, 3, 3, 3};
        n_checks = 0; n_fail = 0; model_drops = 0; cyc = 0;
        rdy_mode = 0; rdy_val = 2'b11;
        rst_n = 1'b0;
        cif.from_network_bridge_tvalid = 1'b0;
        cif.from_network_bridge_tdata  = '0;
        cif.from_network_bridge_tkeep  = '0;
        cif.from_network_bridge_tid    = '0;
        cif.from_network_bridge_tdest  = '0;
        cif.from_network_bridge_tuser  = '0;
        cif.from_network_bridge_tlast  = 1'b0;
        idle(3);

        check("rst_in_tready", cif.from_network_bridge_tready, 0);
        check("rst_tvalid", cif.to_ctrl_tvalid, 0);
        check("rst_tdata", cif.to_ctrl_tdata, 0);
        check("rst_tkeep", cif.to_ctrl_tkeep, 0);
        check("rst_tid", cif.to_ctrl_tid, 0);
        check("rst_tdest", cif.to_ctrl_tdest, 0);
        check("rst_tuser", cif.to_ctrl_tuser, 0);
        check("rst_tlast", cif.to_ctrl_tlast, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(1);

        // Forward to channel 1; the tid change on beat 2 must not show.
        rdy_val = 2'b10;
        idle(1);
        base = log_q.size();
        pd[0] = 64'hABABABABCDCDCDCD;
        pd[1] = 64'hEFEFEFEFEFEFEFEF;
        send_pkt(16'hEFEF, 16'hAEAE, 16'hACAC, 32'hA0A0A0A0, 2, 2, t0, tl);
        idle(4);
        check("t1_beats", log_q.size() - base, 2);
        if (log_q.size() - base >= 2) begin
            check("t1_b0_ch", log_q[base].ch, 1);
            check("t1_b0_data", log_q[base].data, 64'hABABABABCDCDCDCD);
            check("t1_b0_tid", log_q[base].tid, 16'hAEAE);
            check("t1_b0_last", log_q[base].last, 0);
            check("t1_b1_data", log_q[base+1].data, 64'hEFEFEFEFEFEFEFEF);
            check("t1_b1_tid", log_q[base+1].tid, 16'hAEAE);
            check("t1_b1_last", log_q[base+1].last, 1);
            check("t1_latency", log_q[base].cyc - t0, 2);
        end

        // Drop a 3-beat packet: header decode + 3 accept cycles.
        rdy_val = 2'b11;
        idle(1);
        base = log_q.size();
        for (int i = 0; i < 3; i++) pd[i] = 64'h2000 + 64'(i);
        send_pkt(16'h1234, 16'h0001, 16'h0001, 32'h0A000001, 3, 3, t0, tl);
        check("t2_span", tl - t0 + 1, 4);
        idle(2);
        check("t2_drop_count", drop_count, 1);
        check("t2_no_output", log_q.size() - base, 0);

        // Backpressure on channel 0 with channel 1 ready held high.
        rdy_mode = 1;
        rdy_val  = 2'b10;
        idle(1);
        base = log_q.size();
        for (int i = 0; i < 4; i++) pd[i] = 64'h3000_0000_0000_0000 + 64'(i);
        send_pkt(16'hABCD, 16'h0303, 16'h0303, 32'h0A000003, 4, 4, t0, tl);
        idle(12);
        rdy_mode = 0;
        rdy_val  = 2'b11;
        check("t3_beats", log_q.size() - base, 4);
        for (int i = 0; i < 4 && base + i < log_q.size(); i++) begin
            check("t3_ch", log_q[base+i].ch, 0);
            check("t3_order", log_q[base+i].data, 64'h3000_0000_0000_0000 + 64'(i));
        end

        // Back-to-back: the second header waits one cycle for the drain, then one decode cycle.
        idle(1);
        base = log_q.size();
        pd[0] = 64'h4A4A;
        send_pkt(16'hABCD, 16'h0404, 16'h0404, 32'h0A000004, 1, 1, t0, tl);
        pd[0] = 64'h4B00;
        pd[1] = 64'h4B01;
        send_pkt(16'hEFEF, 16'h0405, 16'h0405, 32'h0A000005, 2, 2, t0, tl);
        idle(5);
        check("t4_beats", log_q.size() - base, 3);
        if (log_q.size() - base >= 3) begin
            check("t4_a_ch", log_q[base].ch, 0);
            check("t4_b_ch", log_q[base+1].ch, 1);
            check("t4_gap", log_q[base+1].cyc - log_q[base].cyc, 3);
            check("t4_b_stream", log_q[base+2].cyc - log_q[base+1].cyc, 1);
        end

        // Mid-packet reset after 2 of 4 beats.
        check("t5_pre_drop", drop_count, 1);
        for (int i = 0; i < 4; i++) pd[i] = 64'h5000 + 64'(i);
        send_pkt(16'hABCD, 16'h0505, 16'h0505, 32'h0A000006, 4, 2, t0, tl);
        check("t5_pre_tvalid", cif.to_ctrl_tvalid, 2'b01);
        rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid", cif.to_ctrl_tvalid, 0);
        check("t5_rst_drop", drop_count, 0);
        check("t5_rst_in_tready", cif.from_network_bridge_tready, 0);
        exp_q.delete();
        pkt_q.delete();
        model_drops = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        base = log_q.size();
        pd[0] = 64'h5100;
        pd[1] = 64'h5101;
        send_pkt(16'hABCD, 16'h0506, 16'h0506, 32'h0A000007, 2, 2, t0, tl);
        idle(4);
        check("t5_beats", log_q.size() - base, 2);
        if (log_q.size() - base >= 2) begin
            check("t5_ch", log_q[base].ch, 0);
            check("t5_data0", log_q[base].data, 64'h5100);
            check("t5_data1", log_q[base+1].data, 64'h5101);
        end

        // Saturating 2-bit drop counter.
        for (int k = 0; k < 5; k++) begin
            pd[0] = 64'h6000 + 64'(k);
            send_pkt(16'h0100 + 16'(k), 16'h0600, 16'h0600, 32'h0A000008, 1, 1, t0, tl);
            @(negedge clk);
            check("t6_sat_count", drop_count_small, 64'(exp6[k]));
            check("t6_wide_count", drop_count, 64'(k + 1));
            @(posedge clk);
            #1;
        end

        idle(4);
        check("final_exp_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
